map_table_ss: RTL and testbench
===============================

// Module: map_table_ss
// PURPOSE
//  Superscalar R10K register map table: renames DISPATCH_W instructions per cycle with intra-group bypass.
//  Tracks ready bits from CDB_W completion buses and keeps the architectural map updated by RETIRE_W retirements.
//  Holds NUM_CKPT branch checkpoints for single-cycle mispredict recovery; exception flush restores from the arch map.
//  Sits between decode/dispatch (free list, RS, ROB) and retire; all lookups are combinational.
// PARAMETERS
//  ARCH_REGS  32  architectural registers; AW=$clog2(ARCH_REGS)
//  PHYS_REGS  64  physical registers; PW=$clog2(PHYS_REGS)
//  DISPATCH_W 2   rename slots per cycle (slot 0 oldest)
//  CDB_W      2   completion broadcast ports
//  RETIRE_W   2   retire ports (port 0 oldest)
//  NUM_CKPT   4   branch checkpoints; CW=$clog2(NUM_CKPT)
// PORTS
//  clock        in  1            rising-edge clock
//  reset_n      in  1            async active-low reset
//  disp_valid   in  DISPATCH_W   slot valid
//  disp_src1    in  DISPATCH_W*AW  source-1 arch reg per slot
//  disp_src2    in  DISPATCH_W*AW  source-2 arch reg per slot
//  disp_dst_en  in  DISPATCH_W   slot writes a destination
//  disp_dst     in  DISPATCH_W*AW  dest arch reg per slot
//  disp_dst_p   in  DISPATCH_W*PW  new phys reg from free list per slot
//  src1_p/src2_p out DISPATCH_W*PW renamed source tags
//  src1_rdy/src2_rdy out DISPATCH_W source ready bits
//  told_p       out DISPATCH_W*PW  previous mapping of dest (to ROB)
//  cdb_valid    in  CDB_W        broadcast valid
//  cdb_p        in  CDB_W*PW     completing phys reg
//  ret_valid    in  RETIRE_W     retire valid
//  ret_dst      in  RETIRE_W*AW  retiring dest arch reg
//  ret_p        in  RETIRE_W*PW  retiring phys reg
//  ckpt_take    in  1            snapshot request this cycle
//  ckpt_slot    in  $clog2(DISPATCH_W) branch slot of the snapshot
//  ckpt_avail   out 1            at least one free checkpoint
//  ckpt_id      out CW           id allocated if ckpt_take (lowest free)
//  br_valid     in  1            branch resolved
//  br_id        in  CW           resolved checkpoint
//  br_mispred   in  1            resolved branch mispredicted
//  br_kill_mask in  NUM_CKPT     younger checkpoints to free on mispredict
//  flush        in  1            exception: restore from arch map
// BEHAVIOUR
//  Reset (async, reset_n=0): map[i]=arch[i]=i, ready=1; all checkpoints free; ckpt_avail=1, ckpt_id=0.
//  Arch reg 0: never remapped; lookups return phys 0 ready=1; writes and retirements to it are ignored.
//  Lookup (comb): slot k source = latest earlier slot j<k with dst_en & dst==src (tag disp_dst_p[j], rdy 0),
//   else map entry; rdy forced 1 if the tag matches any valid cdb_p. told_p uses the same bypass.
//  Update (next edge): dispatch writes map[dst]={p,0}, highest slot wins on the same areg; CDB sets ready
//   in map and in every live checkpoint; retire writes arch[dst]=p, highest port wins.
//  Checkpoint: taken if ckpt_take & ckpt_avail & disp_valid[ckpt_slot]; stores map after slots 0..ckpt_slot
//   plus same-cycle CDB readies; ckpt_take with ckpt_avail=0 is ignored.
//  Resolve: br_valid & !br_mispred frees br_id. br_valid & br_mispred: map <= ckpt[br_id] with same-cycle
//   CDB readies applied; frees br_id and br_kill_mask; dispatch and ckpt_take that cycle ignored.
//  Flush: map <= arch with same-cycle retirements applied, all ready=1; all checkpoints freed;
//   dispatch, ckpt_take and br_valid ignored.
//  Priority: reset > flush > mispredict > normal. A checkpoint freed this cycle is reusable next cycle.
//  Retire, CDB and arch-map updates proceed in every non-reset cycle.
// TESTING
//  Reset then read src1=5 -> src1_p=5, rdy=1; told_p of dst 5 = 5.
//  Same group: slot0 r3<-p40, slot1 src1=r3, dst=r3<-p41 -> slot1 src1_p=40 rdy=0, told=40; next cycle map[3]=41.
//  Dispatch r7<-p50; cdb_p=50 the same cycle a later slot reads r7 -> rdy=1; next cycle map[7].ready=1.
//  Ckpt on slot0 (r4<-p45), slot1 r4<-p46, mispredict id0 -> map[4]=45; id0 and kill-mask ids freed.
//  Fill 4 checkpoints -> ckpt_avail=0, 5th take ignored; correct resolve id2 -> next cycle ckpt_id=2.
//  ret r9<-p60 with flush the same cycle -> map[9]=60 ready=1; all checkpoints free; slot-0 dispatch dropped.

Source files
------------

// File: rtl/map_table_ss.sv
// map_table_ss
//   Superscalar R10K-style register map table. Renames DISPATCH_W
//   instructions per cycle with intra-group bypass, tracks ready bits from
//   the completion buses, keeps the architectural (retired) map, and holds
//   NUM_CKPT branch checkpoints for single-cycle mispredict recovery.
//   Exception flush rebuilds the speculative map from the architectural map.
// Ports
//   clock, reset_n                       clock, async active-low reset
//   disp_valid/src1/src2/dst_en/dst/dst_p  rename group (slot 0 oldest)
//   src1_p/src2_p/src1_rdy/src2_rdy      renamed source tags + ready (comb)
//   told_p                               previous mapping of each dest (comb)
//   cdb_valid/cdb_p                      completion broadcasts
//   ret_valid/ret_dst/ret_p              retirements (port 0 oldest)
//   ckpt_take/ckpt_slot                  snapshot request after slot ckpt_slot
//   ckpt_avail/ckpt_id                   free checkpoint present / lowest free id
//   br_valid/br_id/br_mispred/br_kill_mask  branch resolution
//   flush                                exception restore from arch map
module map_table_ss #(
   parameter int ARCH_REGS  = 32,
   parameter int PHYS_REGS  = 64,
   parameter int DISPATCH_W = 2,
   parameter int CDB_W      = 2,
   parameter int RETIRE_W   = 2,
   parameter int NUM_CKPT   = 4,
   localparam int AW = $clog2(ARCH_REGS),
   localparam int PW = $clog2(PHYS_REGS),
   localparam int CW = $clog2(NUM_CKPT),
   localparam int SW = (DISPATCH_W > 1) ? $clog2(DISPATCH_W) : 1
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic [DISPATCH_W-1:0]    disp_valid,
   input  logic [DISPATCH_W*AW-1:0] disp_src1,
   input  logic [DISPATCH_W*AW-1:0] disp_src2,
   input  logic [DISPATCH_W-1:0]    disp_dst_en,
   input  logic [DISPATCH_W*AW-1:0] disp_dst,
   input  logic [DISPATCH_W*PW-1:0] disp_dst_p,
   output logic [DISPATCH_W*PW-1:0] src1_p,
   output logic [DISPATCH_W*PW-1:0] src2_p,
   output logic [DISPATCH_W-1:0]    src1_rdy,
   output logic [DISPATCH_W-1:0]    src2_rdy,
   output logic [DISPATCH_W*PW-1:0] told_p,
   input  logic [CDB_W-1:0]         cdb_valid,
   input  logic [CDB_W*PW-1:0]      cdb_p,
   input  logic [RETIRE_W-1:0]      ret_valid,
   input  logic [RETIRE_W*AW-1:0]   ret_dst,
   input  logic [RETIRE_W*PW-1:0]   ret_p,
   input  logic                     ckpt_take,
   input  logic [SW-1:0]            ckpt_slot,
   output logic                     ckpt_avail,
   output logic [CW-1:0]            ckpt_id,
   input  logic                     br_valid,
   input  logic [CW-1:0]            br_id,
   input  logic                     br_mispred,
   input  logic [NUM_CKPT-1:0]      br_kill_mask,
   input  logic                     flush
);

   logic [PW-1:0]        map_p_q   [ARCH_REGS];
   logic [ARCH_REGS-1:0] map_rdy_q;
   logic [PW-1:0]        arch_p_q  [ARCH_REGS];
   logic [PW-1:0]        ckpt_p_q  [NUM_CKPT][ARCH_REGS];
   logic [ARCH_REGS-1:0] ckpt_rdy_q [NUM_CKPT];
   logic [NUM_CKPT-1:0]  ckpt_busy_q;

   logic [PHYS_REGS-1:0] cdb_hit;
   logic [DISPATCH_W-1:0] slot_wr;
   logic                 do_mispred;
   logic                 ckpt_alloc;
   logic [NUM_CKPT-1:0]  br_onehot;
   logic [NUM_CKPT-1:0]  alloc_onehot;
   logic [NUM_CKPT-1:0]  busy_nxt;

   logic [PW-1:0]        arch_nxt     [ARCH_REGS];
   logic [PW-1:0]        disp_map_p   [ARCH_REGS];
   logic [ARCH_REGS-1:0] disp_map_rdy;
   logic [PW-1:0]        snap_p       [ARCH_REGS];
   logic [ARCH_REGS-1:0] snap_rdy;
   logic [ARCH_REGS-1:0] ckpt_rdy_upd [NUM_CKPT];

   // One bit per physical register completing this cycle.
   always_comb begin
      cdb_hit = '0;
      for (int c = 0; c < CDB_W; c++)
         if (cdb_valid[c]) cdb_hit[cdb_p[c*PW +: PW]] = 1'b1;
   end

   // Arch reg 0 is hardwired, so a write to it never renames anything.
   always_comb begin
      slot_wr = '0;
      for (int k = 0; k < DISPATCH_W; k++)
         slot_wr[k] = disp_valid[k] && disp_dst_en[k] && (disp_dst[k*AW +: AW] != '0);
   end

   // Rename lookup: later slots see the destinations of earlier slots in
   // the same group; the youngest earlier writer wins.
   always_comb begin
      logic [AW-1:0] a1, a2, ad;
      logic [PW-1:0] p1, p2, pd;
      logic          r1, r2;
      src1_p   = '0;
      src2_p   = '0;
      src1_rdy = '0;
      src2_rdy = '0;
      told_p   = '0;
      a1 = '0; a2 = '0; ad = '0;
      p1 = '0; p2 = '0; pd = '0;
      r1 = 1'b0; r2 = 1'b0;
      for (int k = 0; k < DISPATCH_W; k++) begin
         a1 = disp_src1[k*AW +: AW];
         a2 = disp_src2[k*AW +: AW];
         ad = disp_dst[k*AW +: AW];
         p1 = map_p_q[a1];
         r1 = map_rdy_q[a1];
         p2 = map_p_q[a2];
         r2 = map_rdy_q[a2];
         pd = map_p_q[ad];
         for (int j = 0; j < k; j++) begin
            if (slot_wr[j] && disp_dst[j*AW +: AW] == a1) begin
               p1 = disp_dst_p[j*PW +: PW];
               r1 = 1'b0;
            end
            if (slot_wr[j] && disp_dst[j*AW +: AW] == a2) begin
               p2 = disp_dst_p[j*PW +: PW];
               r2 = 1'b0;
            end
            if (slot_wr[j] && disp_dst[j*AW +: AW] == ad)
               pd = disp_dst_p[j*PW +: PW];
         end
         if (a1 == '0) begin
            p1 = '0;
            r1 = 1'b1;
         end
         if (a2 == '0) begin
            p2 = '0;
            r2 = 1'b1;
         end
         if (ad == '0) pd = '0;
         src1_p[k*PW +: PW] = p1;
         src2_p[k*PW +: PW] = p2;
         src1_rdy[k]        = r1 | cdb_hit[p1];
         src2_rdy[k]        = r2 | cdb_hit[p2];
         told_p[k*PW +: PW] = pd;
      end
   end

   // Lowest free checkpoint.
   always_comb begin
      ckpt_id = '0;
      for (int i = NUM_CKPT - 1; i >= 0; i--)
         if (!ckpt_busy_q[i]) ckpt_id = CW'(i);
   end

   assign ckpt_avail   = ~&ckpt_busy_q;
   assign do_mispred   = !flush && br_valid && br_mispred;
   assign ckpt_alloc   = !flush && !do_mispred && ckpt_take && ckpt_avail && disp_valid[ckpt_slot];
   assign br_onehot    = NUM_CKPT'(1) << br_id;
   assign alloc_onehot = NUM_CKPT'(1) << ckpt_id;

   always_comb begin
      busy_nxt = ckpt_busy_q;
      if (flush) begin
         busy_nxt = '0;
      end else if (do_mispred) begin
         busy_nxt = ckpt_busy_q & ~br_kill_mask & ~br_onehot;
      end else begin
         if (br_valid)   busy_nxt = busy_nxt & ~br_onehot;
         if (ckpt_alloc) busy_nxt = busy_nxt | alloc_onehot;
      end
   end

   // Next map contents. The snapshot is the map as it stands after the
   // branch slot, so slots younger than the branch are not in it.
   always_comb begin
      arch_nxt     = arch_p_q;
      disp_map_p   = map_p_q;
      disp_map_rdy = map_rdy_q;
      snap_p       = map_p_q;
      snap_rdy     = map_rdy_q;
      ckpt_rdy_upd = ckpt_rdy_q;
      for (int r = 0; r < RETIRE_W; r++)
         if (ret_valid[r] && ret_dst[r*AW +: AW] != '0)
            arch_nxt[ret_dst[r*AW +: AW]] = ret_p[r*PW +: PW];
      for (int k = 0; k < DISPATCH_W; k++) begin
         if (slot_wr[k]) begin
            disp_map_p[disp_dst[k*AW +: AW]]   = disp_dst_p[k*PW +: PW];
            disp_map_rdy[disp_dst[k*AW +: AW]] = 1'b0;
         end
         if (SW'(k) == ckpt_slot) begin
            snap_p   = disp_map_p;
            snap_rdy = disp_map_rdy;
         end
      end
      // Completions land after the renames, so a tag allocated and
      // completed in the same cycle ends up ready.
      for (int i = 0; i < ARCH_REGS; i++) begin
         disp_map_rdy[i] = disp_map_rdy[i] | cdb_hit[disp_map_p[i]];
         snap_rdy[i]     = snap_rdy[i] | cdb_hit[snap_p[i]];
      end
      for (int c = 0; c < NUM_CKPT; c++)
         for (int i = 0; i < ARCH_REGS; i++)
            ckpt_rdy_upd[c][i] = ckpt_rdy_q[c][i] | cdb_hit[ckpt_p_q[c][i]];
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < ARCH_REGS; i++) begin
            map_p_q[i]  <= PW'(i);
            arch_p_q[i] <= PW'(i);
         end
         map_rdy_q <= '1;
         for (int c = 0; c < NUM_CKPT; c++) begin
            for (int i = 0; i < ARCH_REGS; i++) ckpt_p_q[c][i] <= '0;
            ckpt_rdy_q[c] <= '1;
         end
         ckpt_busy_q <= '0;
      end else begin
         arch_p_q    <= arch_nxt;
         ckpt_rdy_q  <= ckpt_rdy_upd;
         ckpt_busy_q <= busy_nxt;
         if (flush) begin
            map_p_q   <= arch_nxt;
            map_rdy_q <= '1;
         end else if (do_mispred) begin
            map_p_q   <= ckpt_p_q[br_id];
            map_rdy_q <= ckpt_rdy_upd[br_id];
         end else begin
            map_p_q   <= disp_map_p;
            map_rdy_q <= disp_map_rdy;
            if (ckpt_alloc) begin
               ckpt_p_q[ckpt_id]   <= snap_p;
               ckpt_rdy_q[ckpt_id] <= snap_rdy;
            end
         end
      end
   end

endmodule

// File: tb/tb_map_table_ss.sv
// tb_map_table_ss
//   Bench for map_table_ss: a few directed scenarios with literal
//   expectations, then randomized traffic. A behavioural model of the map,
//   arch map and checkpoints predicts every combinational output each cycle.
module tb_map_table_ss;
   localparam int AR = 32, PR = 64, DW = 2, CB = 2, RW = 2, NC = 4;
   localparam int AW = 5, PW = 6, CW = 2, SW = 1;

   logic clock = 1'b0;
   logic reset_n;
   logic [DW-1:0]    disp_valid, disp_dst_en;
   logic [DW*AW-1:0] disp_src1, disp_src2, disp_dst;
   logic [DW*PW-1:0] disp_dst_p;
   logic [DW*PW-1:0] src1_p, src2_p, told_p;
   logic [DW-1:0]    src1_rdy, src2_rdy;
   logic [CB-1:0]    cdb_valid;
   logic [CB*PW-1:0] cdb_p;
   logic [RW-1:0]    ret_valid;
   logic [RW*AW-1:0] ret_dst;
   logic [RW*PW-1:0] ret_p;
   logic             ckpt_take;
   logic [SW-1:0]    ckpt_slot;
   logic             ckpt_avail;
   logic [CW-1:0]    ckpt_id;
   logic             br_valid, br_mispred, flush;
   logic [CW-1:0]    br_id;
   logic [NC-1:0]    br_kill_mask;

   map_table_ss dut (
      .clock(clock), .reset_n(reset_n),
      .disp_valid(disp_valid), .disp_src1(disp_src1), .disp_src2(disp_src2),
      .disp_dst_en(disp_dst_en), .disp_dst(disp_dst), .disp_dst_p(disp_dst_p),
      .src1_p(src1_p), .src2_p(src2_p), .src1_rdy(src1_rdy), .src2_rdy(src2_rdy),
      .told_p(told_p), .cdb_valid(cdb_valid), .cdb_p(cdb_p),
      .ret_valid(ret_valid), .ret_dst(ret_dst), .ret_p(ret_p),
      .ckpt_take(ckpt_take), .ckpt_slot(ckpt_slot), .ckpt_avail(ckpt_avail),
      .ckpt_id(ckpt_id), .br_valid(br_valid), .br_id(br_id),
      .br_mispred(br_mispred), .br_kill_mask(br_kill_mask), .flush(flush)
   );

   always #5 clock = ~clock;

   int n_vec, n_err;

   // stimulus, one entry per slot/port
   int s_v[DW], s_s1[DW], s_s2[DW], s_de[DW], s_d[DW], s_dp[DW];
   int c_v[CB], c_p[CB];
   int r_v[RW], r_d[RW], r_p[RW];
   int t_take, t_slot, b_v, b_id, b_mis, b_kill, t_flush;

   // model state
   int m_map[AR];
   bit m_rdy[AR];
   int m_arch[AR];
   bit m_busy[NC];
   int m_cp[NC][AR];
   bit m_cr[NC][AR];

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic idle();
      for (int k = 0; k < DW; k++) begin
         s_v[k] = 0; s_s1[k] = 0; s_s2[k] = 0; s_de[k] = 0; s_d[k] = 0; s_dp[k] = 0;
      end
      for (int c = 0; c < CB; c++) begin c_v[c] = 0; c_p[c] = 0; end
      for (int r = 0; r < RW; r++) begin r_v[r] = 0; r_d[r] = 0; r_p[r] = 0; end
      t_take = 0; t_slot = 0; b_v = 0; b_id = 0; b_mis = 0; b_kill = 0; t_flush = 0;
   endtask

   task automatic apply();
      for (int k = 0; k < DW; k++) begin
         disp_valid[k]           = s_v[k][0];
         disp_dst_en[k]          = s_de[k][0];
         disp_src1[k*AW +: AW]   = AW'(s_s1[k]);
         disp_src2[k*AW +: AW]   = AW'(s_s2[k]);
         disp_dst[k*AW +: AW]    = AW'(s_d[k]);
         disp_dst_p[k*PW +: PW]  = PW'(s_dp[k]);
      end
      for (int c = 0; c < CB; c++) begin
         cdb_valid[c]       = c_v[c][0];
         cdb_p[c*PW +: PW]  = PW'(c_p[c]);
      end
      for (int r = 0; r < RW; r++) begin
         ret_valid[r]       = r_v[r][0];
         ret_dst[r*AW +: AW] = AW'(r_d[r]);
         ret_p[r*PW +: PW]  = PW'(r_p[r]);
      end
      ckpt_take    = t_take[0];
      ckpt_slot    = SW'(t_slot);
      br_valid     = b_v[0];
      br_id        = CW'(b_id);
      br_mispred   = b_mis[0];
      br_kill_mask = NC'(b_kill);
      flush        = t_flush[0];
   endtask

   function automatic bit on_cdb(input int p);
      for (int c = 0; c < CB; c++)
         if (c_v[c] != 0 && c_p[c] == p) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit writes(input int j);
      return s_v[j] != 0 && s_de[j] != 0 && s_d[j] != 0;
   endfunction

   // What slot k sees for arch reg a: youngest earlier writer in the group,
   // otherwise the committed map; reg 0 is constant.
   task automatic lookup(input int k, input int a, output int p, output bit r);
      p = m_map[a];
      r = m_rdy[a];
      for (int j = k - 1; j >= 0; j--) begin
         if (writes(j) && s_d[j] == a) begin
            p = s_dp[j];
            r = 1'b0;
            break;
         end
      end
      if (a == 0) begin p = 0; r = 1'b1; end
      if (on_cdb(p)) r = 1'b1;
   endtask

   task automatic compare();
      int p; bit r; bit av; int fid;
      for (int k = 0; k < DW; k++) begin
         lookup(k, s_s1[k], p, r);
         chk($sformatf("src1_p[%0d]", k), int'(src1_p[k*PW +: PW]), p);
         chk($sformatf("src1_rdy[%0d]", k), int'(src1_rdy[k]), int'(r));
         lookup(k, s_s2[k], p, r);
         chk($sformatf("src2_p[%0d]", k), int'(src2_p[k*PW +: PW]), p);
         chk($sformatf("src2_rdy[%0d]", k), int'(src2_rdy[k]), int'(r));
         lookup(k, s_d[k], p, r);
         chk($sformatf("told_p[%0d]", k), int'(told_p[k*PW +: PW]), p);
      end
      av = 1'b0; fid = 0;
      for (int i = NC - 1; i >= 0; i--)
         if (!m_busy[i]) begin av = 1'b1; fid = i; end
      chk("ckpt_avail", int'(ckpt_avail), int'(av));
      if (av) chk("ckpt_id", int'(ckpt_id), fid);
   endtask

   task automatic model_reset();
      for (int i = 0; i < AR; i++) begin m_map[i] = i; m_rdy[i] = 1'b1; m_arch[i] = i; end
      for (int c = 0; c < NC; c++) begin
         m_busy[c] = 1'b0;
         for (int i = 0; i < AR; i++) begin m_cp[c][i] = 0; m_cr[c][i] = 1'b1; end
      end
   endtask

   task automatic model_update();
      int na[AR]; bit alloc; int aid;
      na = m_arch;
      for (int r = 0; r < RW; r++)
         if (r_v[r] != 0 && r_d[r] != 0) na[r_d[r]] = r_p[r];
      for (int c = 0; c < NC; c++)
         if (m_busy[c])
            for (int i = 0; i < AR; i++)
               if (on_cdb(m_cp[c][i])) m_cr[c][i] = 1'b1;
      if (t_flush != 0) begin
         m_map = na;
         foreach (m_rdy[i]) m_rdy[i] = 1'b1;
         foreach (m_busy[c]) m_busy[c] = 1'b0;
      end else if (b_v != 0 && b_mis != 0) begin
         m_map = m_cp[b_id];
         m_rdy = m_cr[b_id];
         m_busy[b_id] = 1'b0;
         for (int c = 0; c < NC; c++) if (b_kill[c]) m_busy[c] = 1'b0;
      end else begin
         alloc = 1'b0; aid = 0;
         if (t_take != 0 && s_v[t_slot] != 0)
            for (int c = NC - 1; c >= 0; c--)
               if (!m_busy[c]) begin alloc = 1'b1; aid = c; end
         if (b_v != 0) m_busy[b_id] = 1'b0;
         for (int k = 0; k < DW; k++) begin
            if (writes(k)) begin m_map[s_d[k]] = s_dp[k]; m_rdy[s_d[k]] = 1'b0; end
            if (alloc && k == t_slot) begin
               m_cp[aid] = m_map;
               m_cr[aid] = m_rdy;
               for (int i = 0; i < AR; i++) if (on_cdb(m_map[i])) m_cr[aid][i] = 1'b1;
               m_busy[aid] = 1'b1;
            end
         end
         for (int i = 0; i < AR; i++) if (on_cdb(m_map[i])) m_rdy[i] = 1'b1;
      end
      m_arch = na;
   endtask

   task automatic cycle();
      #1;
      compare();
      model_update();
      @(posedge clock);
      @(negedge clock);
   endtask

   function automatic int pick_reg();
      if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 7));
      return int'($urandom_range(0, AR - 1));
   endfunction

   task automatic rand_inputs();
      int q[$];
      idle();
      for (int k = 0; k < DW; k++) begin
         s_v[k]  = int'($urandom_range(0, 1));
         s_s1[k] = pick_reg();
         s_s2[k] = pick_reg();
         s_de[k] = ($urandom_range(0, 3) != 0) ? 1 : 0;
         s_d[k]  = pick_reg();
         s_dp[k] = int'($urandom_range(0, PR - 1));
      end
      for (int c = 0; c < CB; c++) begin
         c_v[c] = int'($urandom_range(0, 1));
         c_p[c] = ($urandom_range(0, 1) == 1) ? s_dp[$urandom_range(0, DW - 1)]
                                              : int'($urandom_range(0, PR - 1));
      end
      for (int r = 0; r < RW; r++) begin
         r_v[r] = int'($urandom_range(0, 1));
         r_d[r] = pick_reg();
         r_p[r] = int'($urandom_range(0, PR - 1));
      end
      t_take = ($urandom_range(0, 2) == 0) ? 1 : 0;
      t_slot = int'($urandom_range(0, DW - 1));
      for (int c = 0; c < NC; c++) if (m_busy[c]) q.push_back(c);
      if (q.size() > 0 && $urandom_range(0, 3) == 0) begin
         b_v    = 1;
         b_id   = q[$urandom_range(0, q.size() - 1)];
         b_mis  = ($urandom_range(0, 2) == 0) ? 1 : 0;
         b_kill = int'($urandom_range(0, (1 << NC) - 1));
      end
      t_flush = ($urandom_range(0, 59) == 0) ? 1 : 0;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      idle();
      apply();
      reset_n = 1'b0;
      model_reset();
      repeat (3) @(negedge clock);
      reset_n = 1'b1;

      // reset mapping is identity, all ready
      idle(); s_s1[0] = 5; s_de[0] = 1; s_d[0] = 5; apply(); #1;
      chk("rst_src1_p", int'(src1_p[0 +: PW]), 5);
      chk("rst_src1_rdy", int'(src1_rdy[0]), 1);
      chk("rst_told_p", int'(told_p[0 +: PW]), 5);
      chk("rst_ckpt_avail", int'(ckpt_avail), 1);
      chk("rst_ckpt_id", int'(ckpt_id), 0);
      cycle();

      // intra-group bypass
      idle();
      s_v[0] = 1; s_de[0] = 1; s_d[0] = 3; s_dp[0] = 40;
      s_v[1] = 1; s_s1[1] = 3; s_de[1] = 1; s_d[1] = 3; s_dp[1] = 41;
      apply(); #1;
      chk("byp_src1_p", int'(src1_p[PW +: PW]), 40);
      chk("byp_src1_rdy", int'(src1_rdy[1]), 0);
      chk("byp_told0", int'(told_p[0 +: PW]), 3);
      chk("byp_told1", int'(told_p[PW +: PW]), 40);
      cycle();
      idle(); s_s1[0] = 3; apply(); #1;
      chk("byp_next_map3", int'(src1_p[0 +: PW]), 41);
      chk("byp_next_rdy3", int'(src1_rdy[0]), 0);
      cycle();

      // same-cycle completion of a freshly renamed tag
      idle();
      s_v[0] = 1; s_de[0] = 1; s_d[0] = 7; s_dp[0] = 50;
      s_v[1] = 1; s_s1[1] = 7;
      c_v[0] = 1; c_p[0] = 50;
      apply(); #1;
      chk("cdb_byp_p", int'(src1_p[PW +: PW]), 50);
      chk("cdb_byp_rdy", int'(src1_rdy[1]), 1);
      cycle();
      idle(); s_s1[0] = 7; apply(); #1;
      chk("cdb_next_rdy7", int'(src1_rdy[0]), 1);
      cycle();

      // checkpoint after slot 0, mispredict restores it and frees kill mask
      idle();
      s_v[0] = 1; s_de[0] = 1; s_d[0] = 4; s_dp[0] = 45;
      s_v[1] = 1; s_de[1] = 1; s_d[1] = 4; s_dp[1] = 46;
      t_take = 1; t_slot = 0;
      apply(); #1;
      chk("ck_first_id", int'(ckpt_id), 0);
      cycle();
      idle();
      s_v[0] = 1; s_de[0] = 1; s_d[0] = 10; s_dp[0] = 47; s_s1[0] = 4;
      t_take = 1; t_slot = 0;
      apply(); #1;
      chk("ck_pre_map4", int'(src1_p[0 +: PW]), 46);
      chk("ck_second_id", int'(ckpt_id), 1);
      cycle();
      idle();
      b_v = 1; b_id = 0; b_mis = 1; b_kill = 2;
      s_v[1] = 1; s_de[1] = 1; s_d[1] = 12; s_dp[1] = 33;
      apply();
      cycle();
      idle();
      s_s1[0] = 4; s_s2[0] = 10; s_s1[1] = 12;
      s_v[0] = 1; t_take = 1; t_slot = 0;
      apply(); #1;
      chk("mis_map4", int'(src1_p[0 +: PW]), 45);
      chk("mis_rdy4", int'(src1_rdy[0]), 0);
      chk("mis_map10", int'(src2_p[0 +: PW]), 10);
      chk("mis_map12_dropped", int'(src1_p[PW +: PW]), 12);
      chk("mis_ckpt_id", int'(ckpt_id), 0);
      cycle();
      idle(); apply(); #1;
      chk("mis_kill_freed", int'(ckpt_id), 1);
      cycle();

      // flush with a same-cycle retirement
      idle();
      r_v[0] = 1; r_d[0] = 9; r_p[0] = 60;
      t_flush = 1;
      s_v[0] = 1; s_de[0] = 1; s_d[0] = 9; s_dp[0] = 61;
      t_take = 1; t_slot = 0;
      apply();
      cycle();
      idle(); s_s1[0] = 9; s_s2[0] = 3; s_s1[1] = 4; apply(); #1;
      chk("fl_map9", int'(src1_p[0 +: PW]), 60);
      chk("fl_rdy9", int'(src1_rdy[0]), 1);
      chk("fl_map3", int'(src2_p[0 +: PW]), 3);
      chk("fl_map4", int'(src1_p[PW +: PW]), 4);
      chk("fl_ckpt_avail", int'(ckpt_avail), 1);
      chk("fl_ckpt_id", int'(ckpt_id), 0);
      cycle();

      // fill all checkpoints, overflow take ignored, free id 2
      for (int i = 0; i < NC; i++) begin
         idle(); s_v[0] = 1; t_take = 1; apply(); #1;
         chk($sformatf("fill_id%0d", i), int'(ckpt_id), i);
         cycle();
      end
      idle(); s_v[0] = 1; t_take = 1; apply(); #1;
      chk("full_avail", int'(ckpt_avail), 0);
      cycle();
      idle(); b_v = 1; b_id = 2; apply(); #1;
      chk("full_after_extra_take", int'(ckpt_avail), 0);
      cycle();
      idle(); apply(); #1;
      chk("freed_id2", int'(ckpt_id), 2);
      chk("freed_avail", int'(ckpt_avail), 1);
      cycle();

      for (int n = 0; n < 3000; n++) begin
         rand_inputs();
         apply();
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
